// File: rtl/permutation_round_ctrl.sv
// Round sequencer for the Ascon permutation: holds the 320-bit state and round index.
// Optional p8 support (mode 2'b10) is compiled in when ASCON_P8_EN is defined.
module permutation_round_ctrl (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [4:0][63:0] state_i,
    input  logic [4:0][63:0] round_data_i,
    output logic [4:0][63:0] state_o,
    output logic [3:0]       round_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t       fsm;
    logic [3:0] first_round;

    // Every permutation ends on round 11, so the mode only picks the entry point.
    always_comb begin
        first_round = 4'd0;
        case (mode_i)
            2'b01:   first_round = 4'd6;
`ifdef ASCON_P8_EN
            2'b10:   first_round = 4'd4;
`endif
            default: first_round = 4'd0;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm     <= IDLE;
            state_o <= '0;
            round_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (fsm)
                RUN: begin
                    state_o <= round_data_i;
                    if (round_o == 4'd11) begin
                        fsm    <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        round_o <= round_o + 4'd1;
                    end
                end
                default: begin
                    if (start_i) begin
                        fsm     <= RUN;
                        state_o <= state_i;
                        round_o <= first_round;
                        busy_o  <= 1'b1;
                        done_o  <= 1'b0;
                    end else begin
                        fsm    <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Randomised bench for permutation_round_ctrl: per-cycle comparison against a
// trajectory scoreboard, plus hand-computed loopback, back-to-back and reset checks.
module tb_permutation_round_ctrl;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic [4:0][63:0] state_in;
    logic [4:0][63:0] round_data;
    logic [4:0][63:0] state_out;
    logic [3:0]       round;
    logic             busy;
    logic             done;
    bit               chain_sel;

    int vectors;
    int miscompares;

    permutation_round_ctrl dut (
        .clock_i      (clk),
        .resetb_i     (rst_n),
        .start_i      (start),
        .mode_i       (mode),
        .state_i      (state_in),
        .round_data_i (round_data),
        .state_o      (state_out),
        .round_o      (round),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in round chain: word-0 increment (loopback) or a round-dependent mixer.
    function automatic logic [4:0][63:0] chain(input logic [4:0][63:0] s, input logic [3:0] r, input bit sel);
        logic [4:0][63:0] o;
        o = s;
        if (!sel) begin
            o[0] = s[0] + 64'd1;
        end else begin
            for (int i = 0; i < 5; i++)
                o[i] = s[i] ^ {s[(i + 1) % 5][62:0], s[(i + 1) % 5][63]} ^ (64'(r) << (8 * i));
        end
        return o;
    endfunction

    always_comb round_data = chain(state_out, round, chain_sel);

    function automatic logic [3:0] first_of(input logic [1:0] m);
        case (m)
            2'b01:   return 4'd6;
`ifdef ASCON_P8_EN
            2'b10:   return 4'd4;
`endif
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [4:0][63:0] rand_state();
        logic [4:0][63:0] s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Scoreboard: an accepted start expands into its full expected output trajectory.
    typedef struct {
        logic             busy;
        logic             done;
        logic [3:0]       round;
        logic [4:0][63:0] st;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur.busy  = 1'b0;
            cur.done  = 1'b0;
            cur.round = '0;
            cur.st    = '0;
        end else begin
            if (start && !cur.busy) begin
                exp_t             e;
                logic [4:0][63:0] s;
                logic [3:0]       r;
                int               n;
                q.delete();
                r = first_of(mode);
                n = 12 - int'(r);
                s = state_in;
                for (int k = 0; k < n; k++) begin
                    e.busy = 1'b1; e.done = 1'b0; e.round = r; e.st = s;
                    q.push_back(e);
                    s = chain(s, r, chain_sel);
                    if (k < n - 1) r = r + 4'd1;
                end
                e.busy = 1'b0; e.done = 1'b1; e.round = r; e.st = s;
                q.push_back(e);
            end
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur.busy = 1'b0;
                cur.done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy",  320'(busy),      320'(cur.busy));
            chk("done",  320'(done),      320'(cur.done));
            chk("round", 320'(round),     320'(cur.round));
            chk("state", 320'(state_out), 320'(cur.st));
        end
    end

    task automatic wait_idle();
        bit ok;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1'b1;
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic loopback(input logic [1:0] m, input int n, input logic [3:0] first, input string tag);
        int e, busy_cnt;
        bit got;
        chain_sel = 1'b0;
        state_in  = '0;
        wait_idle();
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1 start = 1'b0;
        e = 1; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) begin
                    chk({tag, "_round_seq"}, 320'(round), 320'(first + 4'(busy_cnt)));
                    busy_cnt++;
                end
                @(posedge clk);
                e++;
            end
        end
        if (!got) begin
            timeout({tag, "_done"});
        end else begin
            chk({tag, "_latency"},  320'(e),              320'(n + 1));
            chk({tag, "_busy_len"}, 320'(busy_cnt),       320'(n));
            chk({tag, "_word0"},    320'(state_out[0]),   320'(n));
            chk({tag, "_words14"},  320'(state_out[4:1]), 320'(0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        mode        = 2'b00;
        state_in    = '0;
        chain_sel   = 1'b0;

        #2;
        chk("reset_busy",  320'(busy),      320'(0));
        chk("reset_done",  320'(done),      320'(0));
        chk("reset_round", 320'(round),     320'(0));
        chk("reset_state", 320'(state_out), 320'(0));
        #20 rst_n = 1'b1;

        loopback(2'b00, 12, 4'd0, "p12");
        loopback(2'b01, 6,  4'd6, "p6");
`ifdef ASCON_P8_EN
        loopback(2'b10, 8,  4'd4, "p8");
`else
        loopback(2'b10, 12, 4'd0, "p8_off");
`endif
        loopback(2'b11, 12, 4'd0, "reserved");

        begin : back_to_back
            int last_done, ndone;
            bit seen_busy;
            chain_sel = 1'b0;
            state_in  = '0;
            wait_idle();
            @(posedge clk); #1;
            mode  = 2'b01;
            start = 1'b1;
            last_done = -1; ndone = 0; seen_busy = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (busy) seen_busy = 1'b1;
                if (seen_busy) chk("b2b_no_idle", 320'(busy | done), 320'(1));
                if (done) begin
                    chk("b2b_word0", 320'(state_out[0]), 320'(6));
                    if (last_done >= 0) chk("b2b_period", 320'(c - last_done), 320'(7));
                    last_done = c;
                    ndone++;
                end
            end
            if (ndone < 3) timeout("b2b_dones");
            @(posedge clk); #1 start = 1'b0;
        end

        begin : reset_mid
            bit hit;
            chain_sel = 1'b0;
            state_in  = '0;
            wait_idle();
            @(posedge clk); #1;
            mode  = 2'b00;
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clk);
                if (busy && round == 4'd5) hit = 1'b1;
            end
            if (!hit) timeout("rst_round5");
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy",  320'(busy),      320'(0));
            chk("rst_done",  320'(done),      320'(0));
            chk("rst_round", 320'(round),     320'(0));
            chk("rst_state", 320'(state_out), 320'(0));
            repeat (2) begin
                @(negedge clk);
                chk("rst_no_done", 320'(done), 320'(0));
            end
            #1 rst_n = 1'b1;
            loopback(2'b00, 12, 4'd0, "post_rst");
        end

        wait_idle();
        chain_sel = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start    = ($urandom_range(3) == 0);
            mode     = 2'($urandom);
            state_in = rand_state();
            if ($urandom_range(700) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/permutation_round_ctrl.md
# permutation_round_ctrl

Sequential driver for the Ascon permutation datapath. It holds the 320-bit state register and the 4-bit round counter. Each cycle it feeds the registered state and the current round index to `constant_addition`, which starts the combinational round chain, and it captures the chain's result on the next clock edge. It sits directly upstream of `constant_addition`. It sequences p12 and p6 permutations, plus p8 when configured, under a start/done handshake.

## Interface
Parameters:
- None. The round count is selected at run time by `mode_i`.

Ports:
- `clock_i`  in  1  system clock; all state updates on the rising edge
- `resetb_i`  in  1  one clock; reset is asynchronous and active-low
- `start_i`  in  1  request a permutation; sampled only in IDLE or DONE
- `mode_i`  in  2  `00` = p12 (first round 0), `01` = p6 (first round 6), `10` = p8 (first round 4, see Configuration), `11` = reserved and treated as p12
- `state_i`  in  `type_state` (5x64)  state loaded when a start is accepted
- `round_data_i`  in  `type_state`  output of the round chain (constant addition, substitution, linear diffusion) for `state_o`/`round_o`
- `state_o`  out  `type_state`  registered state; drives `constant_add_i`
- `round_o`  out  4  registered round index; drives `round_i`
- `busy_o`  out  1  high in RUN
- `done_o`  out  1  one-cycle pulse; `state_o` holds the final permutation result

## Operation
- FSM states: IDLE, RUN, DONE. Reset value is IDLE.
- IDLE or DONE with `start_i`=1:
  - `state_o` <= `state_i`
  - `round_o` <= first round per `mode_i`
  - next state RUN
- RUN:
  - `state_o` <= `round_data_i` every cycle
  - if `round_o` /= 11: `round_o` <= `round_o`+1
  - if `round_o` = 11: `round_o` holds; next state DONE
- DONE: `done_o`=1. Next state is RUN if `start_i`=1 (back-to-back permutation), otherwise IDLE. `state_o` holds its value in both cases unless a new load occurs.
- IDLE: `state_o` and `round_o` hold. `start_i` is ignored while in RUN, with no queuing.
- The counter never exceeds 11 and never wraps. Values 12–15 are unreachable.
- `busy_o` = (state = RUN). `done_o` = (state = DONE). Both are decoded from registered state only, with no combinational path from any input.
- Reset mid-operation: all registers clear immediately (asynchronously), the FSM returns to IDLE, and the in-flight permutation is discarded without a `done_o` pulse.
- Reset values: `state_o`=0 (all 320 bits), `round_o`=0, `busy_o`=0, `done_o`=0.

## Timing
- Start accepted at edge E0, which loads the state and the first round.
- RUN occupies the N cycles after E0, where N = 12, 6 or 8.
- The last round result is captured at edge E0+N. `done_o` is high during the cycle after E0+N.
- Start-to-done latency is N+1 edges: 13 for p12, 7 for p6, 9 for p8.
- `round_o` during RUN:
  - p12: 0,1,…,11
  - p6: 6,…,11
  - p8: 4,…,11
- `round_data_i` must settle within one clock period. The round chain is combinational from `state_o`/`round_o`.
- Back-to-back: `start_i` high during DONE makes the next RUN begin at the following edge, so there are no idle cycles between permutations.

## Configuration
- Macro `ASCON_P8_EN`.
  - Defined: `mode_i`=`10` selects p8 (first round 4, 8 rounds).
  - Undefined: `mode_i`=`10` behaves as p12. The p8 decode logic is absent.

## Test plan
- Loopback p12: `round_data_i` = `state_o` with word 0 incremented by 1; `state_i` all zero; `start_i` pulse with `mode_i`=`00`.
  - `round_o` steps 0…11.
  - `busy_o` is high for 12 cycles.
  - `done_o` pulses once, 13 edges after start.
  - `state_o`[0] = 12 and words 1–4 = 0.
- Same loopback with `mode_i`=`01`: `round_o` steps 6…11, `done_o` at edge 7, `state_o`[0] = 6.
- `mode_i`=`10`:
  - With `ASCON_P8_EN`: 8 rounds starting at 4, `state_o`[0] = 8.
  - Without it: 12 rounds, `state_o`[0] = 12.
- `start_i` held high throughout, p6 loopback: `done_o` pulses every 7 cycles. Each permutation restarts from `state_i`, so `state_o`[0] = 6 at each `done_o`. The FSM never passes through IDLE.
- Drop `resetb_i` at round 5 of a p12: outputs are zero immediately (asynchronous), with no `done_o`. After release, a new start runs a full p12 correctly.
- Real round chain wired in: `state_i` = ASCON-128 initialisation state (IV 0x80400c0600000000, key and nonce = 0), p12. `state_o` at `done_o` matches the reference software model bit-for-bit.
